stopwatch_ctrl: RTL
===================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter CNT_W, default 24: width of the elapsed-time counter.
REQ-002 Parameter DEB_CYC, default 4: consecutive identical samples needed to accept a button level (range 1..255).
REQ-003 Parameter LAP_DEPTH, default 4: lap FIFO entries (power of 2, at least 2).
REQ-004 clk  in  1  clock; all state changes on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 tick_i  in  1  time-base pulse; one count per cycle it is high.
REQ-007 start_i, stop_i, split_i, lap_i, clear_i  in  1 each  raw asynchronous push buttons, active-high.
REQ-008 rd_i  in  1  pop request for the lap FIFO.
REQ-009 time_o  out  CNT_W  live elapsed count.
REQ-010 display_o  out  CNT_W  displayed count: live value, or the frozen split value.
REQ-011 running_o  out  1  high in RUN or SPLIT.
REQ-012 frozen_o  out  1  high in SPLIT.
REQ-013 lap_data_o  out  CNT_W  head of the lap FIFO (first-word fall-through).
REQ-014 lap_valid_o  out  1  FIFO not empty.
REQ-015 lap_count_o  out  $clog2(LAP_DEPTH)+1  current FIFO occupancy.
REQ-016 lap_ovf_o  out  1  sticky flag: a lap was dropped because the FIFO was full.
REQ-017 wrap_o  out  1  one-cycle pulse when the counter wraps to 0.

Function
REQ-018 Each button path SHALL have a 2-FF synchronizer, then a debouncer that accepts a new level only after DEB_CYC consecutive equal synchronized samples.
REQ-019 An accepted 0->1 transition SHALL produce exactly one one-cycle press pulse, DEB_CYC+2 cycles after the raw edge. Holding a button SHALL NOT repeat the pulse.
REQ-020 The FSM states SHALL be IDLE, RUN, SPLIT and STOP; the reset state is IDLE.
REQ-021 IDLE: start -> RUN.
REQ-022 RUN: stop -> STOP; else split -> SPLIT, capturing time_o into the freeze register.
REQ-023 SPLIT: stop -> STOP; else split -> RUN.
REQ-024 STOP: start -> RUN (resume without clearing the count).
REQ-025 clear in IDLE or STOP SHALL go to IDLE, zero the counter and flush the FIFO. clear SHALL be ignored in RUN and SPLIT.
REQ-026 When several presses arrive in the same cycle, the priority SHALL be stop > split > start; lap is handled independently of the FSM.
REQ-027 The counter SHALL increment on tick_i only when the registered state is RUN or SPLIT; counting continues while the display is frozen.
REQ-028 On tick_i at the all-ones count, the counter SHALL wrap to 0 and wrap_o SHALL pulse for one cycle.
REQ-029 display_o SHALL equal the freeze register in SPLIT and time_o in every other state. Leaving SPLIT SHALL return display_o to the live value on the next cycle.
REQ-030 A lap press in RUN or SPLIT SHALL push time_o into the FIFO; lap presses in IDLE or STOP SHALL be ignored.
REQ-031 A push when full SHALL drop the value and set lap_ovf_o; lap_ovf_o SHALL clear only on clear or reset.
REQ-032 rd_i with lap_valid_o high SHALL pop one entry; rd_i when empty SHALL be ignored.
REQ-033 A push and pop in the same cycle SHALL both take effect, including when the FIFO is full; occupancy is unchanged.
REQ-034 Occupancy SHALL never exceed LAP_DEPTH, and the FIFO pointers SHALL wrap modulo LAP_DEPTH.

Reset
REQ-035 rst SHALL immediately force the following: state IDLE; counter, freeze register, FIFO pointers and occupancy 0; lap_ovf_o, wrap_o, running_o and frozen_o 0; all debouncer and synchronizer state 0. This applies at any time, including mid-count or mid-debounce.
REQ-036 After rst is released, a button already held high SHALL produce one press once it is debounced.

Verification (CNT_W=8, DEB_CYC=4, LAP_DEPTH=2)
REQ-037 start held 3 cycles, then released -> no press, state stays IDLE. start held 10 cycles -> one press after 6 cycles, state RUN, running_o=1.
REQ-038 RUN, 5 ticks, split, 3 ticks -> display_o=5, time_o=8, frozen_o=1. Split again -> display_o=8.
REQ-039 RUN at count 255, one tick -> time_o=0, wrap_o high for exactly 1 cycle.
REQ-040 Three laps at counts 2, 4, 6 -> lap_count_o=2, head=2, lap_ovf_o=1. Two pops -> values 2 then 4, lap_valid_o=0.
REQ-041 stop and split pressed in the same cycle from RUN -> STOP. clear -> IDLE, time_o=0, lap_count_o=0, lap_ovf_o=0.
REQ-042 rst asserted mid-RUN at count 37 with 1 lap stored -> all outputs 0, state IDLE.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch controller with debounced buttons, split display and lap FIFO
//
// Purpose: counts tick_i pulses while running. Five raw push buttons pass through
// a 2-FF synchronizer and a debouncer, then drive an IDLE/RUN/SPLIT/STOP FSM.
// A small first-word-fall-through FIFO records lap times.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   tick_i                   time base; one count per high cycle
//   start_i stop_i split_i   raw buttons, active-high
//   lap_i clear_i            raw buttons, active-high
//   rd_i                     pop the lap FIFO head
//   time_o                   live elapsed count
//   display_o                live count, or the frozen split value in SPLIT
//   running_o / frozen_o     RUN or SPLIT / SPLIT only
//   lap_data_o/lap_valid_o   FIFO head (0 when empty) / FIFO not empty
//   lap_count_o              FIFO occupancy
//   lap_ovf_o                sticky: a lap was dropped while full
//   wrap_o                   one-cycle pulse when the counter rolls over to 0
module stopwatch_ctrl #(
    parameter int CNT_W     = 24,
    parameter int DEB_CYC   = 4,
    parameter int LAP_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tick_i,
    input  logic                         start_i,
    input  logic                         stop_i,
    input  logic                         split_i,
    input  logic                         lap_i,
    input  logic                         clear_i,
    input  logic                         rd_i,
    output logic [CNT_W-1:0]             time_o,
    output logic [CNT_W-1:0]             display_o,
    output logic                         running_o,
    output logic                         frozen_o,
    output logic [CNT_W-1:0]             lap_data_o,
    output logic                         lap_valid_o,
    output logic [$clog2(LAP_DEPTH):0]   lap_count_o,
    output logic                         lap_ovf_o,
    output logic                         wrap_o
);

    localparam int PW = $clog2(LAP_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(LAP_DEPTH);
    localparam logic [7:0]    DEB_LAST = 8'(DEB_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_SPLIT, S_STOP} state_t;

    // Button bit order: 0 start, 1 stop, 2 split, 3 lap, 4 clear
    logic [4:0]       w_btn_raw;
    logic [4:0]       r_sync1;
    logic [4:0]       r_sync2;
    logic [4:0]       r_level;
    logic [4:0]       r_press;
    logic [7:0]       r_deb_cnt [5];

    state_t           r_state;
    state_t           w_next;
    logic             w_clear_act;
    logic             w_capture;
    logic             w_counting;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_freeze;
    logic             r_wrap;

    logic [CNT_W-1:0] r_mem [LAP_DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_ovf;
    logic             w_lap_req;
    logic             w_full;
    logic             w_pop;
    logic             w_push;

    assign w_btn_raw = {clear_i, lap_i, split_i, stop_i, start_i};

    // The debouncer counts consecutive synchronized samples that disagree with the
    // accepted level; any agreeing sample restarts the count. The press pulse is
    // registered on the acceptance edge, so it appears DEB_CYC+2 cycles after the raw edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_level <= '0;
            r_press <= '0;
            for (int i = 0; i < 5; i++) r_deb_cnt[i] <= '0;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 5; i++) begin
                r_press[i] <= 1'b0;
                if (r_sync2[i] == r_level[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DEB_LAST) begin
                    r_level[i]   <= r_sync2[i];
                    r_deb_cnt[i] <= '0;
                    r_press[i]   <= r_sync2[i];
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // stop outranks split, split outranks start; clear only acts when not counting
    always_comb begin
        w_next      = r_state;
        w_clear_act = 1'b0;
        w_capture   = 1'b0;
        w_counting  = (r_state == S_RUN) || (r_state == S_SPLIT);
        case (r_state)
            S_IDLE: begin
                if (r_press[4])      w_clear_act = 1'b1;
                else if (r_press[0]) w_next = S_RUN;
            end
            S_RUN: begin
                if (r_press[1]) begin
                    w_next = S_STOP;
                end else if (r_press[2]) begin
                    w_next    = S_SPLIT;
                    w_capture = 1'b1;
                end
            end
            S_SPLIT: begin
                if (r_press[1])      w_next = S_STOP;
                else if (r_press[2]) w_next = S_RUN;
            end
            S_STOP: begin
                if (r_press[4]) begin
                    w_next      = S_IDLE;
                    w_clear_act = 1'b1;
                end else if (r_press[0]) begin
                    w_next = S_RUN;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_freeze <= '0;
            r_wrap   <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (w_clear_act) begin
                r_cnt <= '0;
            end else if (tick_i && w_counting) begin
                r_cnt  <= r_cnt + 1'b1;
                r_wrap <= &r_cnt;
            end
            if (w_capture) r_freeze <= r_cnt;
        end
    end

    // A push into a full FIFO is accepted when a pop frees the head slot in the same cycle
    assign w_lap_req = r_press[3] && w_counting;
    assign w_full    = (r_count == DEPTH_C);
    assign w_pop     = rd_i && (r_count != '0);
    assign w_push    = w_lap_req && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= r_cnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else if (w_clear_act) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_lap_req && w_full && !w_pop) r_ovf <= 1'b1;
        end
    end

    assign time_o      = r_cnt;
    assign display_o   = (r_state == S_SPLIT) ? r_freeze : r_cnt;
    assign running_o   = w_counting;
    assign frozen_o    = (r_state == S_SPLIT);
    // Head is masked when empty so stale storage never shows after reset or clear
    assign lap_data_o  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign lap_valid_o = (r_count != '0);
    assign lap_count_o = r_count;
    assign lap_ovf_o   = r_ovf;
    assign wrap_o      = r_wrap;

endmodule
